// File: rtl/arm_pkg.sv
// Shared encodings for the execute stage: ALU opcodes, barrel-shift types and
// operand forwarding selects.
package arm_pkg;

  localparam logic [3:0] ALU_MOV = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_ADC = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_SBC = 4'b0101;
  localparam logic [3:0] ALU_AND = 4'b0110;
  localparam logic [3:0] ALU_ORR = 4'b0111;
  localparam logic [3:0] ALU_EOR = 4'b1000;
  localparam logic [3:0] ALU_MVN = 4'b1001;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_t;

  localparam logic [1:0] FWD_REG  = 2'b00;
  localparam logic [1:0] FWD_MEM  = 2'b01;
  localparam logic [1:0] FWD_WB   = 2'b10;
  localparam logic [1:0] FWD_REG2 = 2'b11;

endpackage

// File: rtl/exe_stage_val2_gen.sv
// Operand-2 generator: rotated 8-bit immediate, 12-bit memory offset, or
// barrel-shifted register operand.
module val2_gen
  import arm_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              i_imm,
  input  logic              i_mem_rw,
  input  logic [11:0]       i_shift_operand,
  input  logic [DATA_W-1:0] i_rm,
  output logic [DATA_W-1:0] o_val2
);

  logic [DATA_W-1:0] w_imm8;
  logic [4:0]        w_rot;
  logic [4:0]        w_amt;
  logic [DATA_W-1:0] w_imm_rot;
  logic [DATA_W-1:0] w_shifted;

  assign w_imm8 = {{(DATA_W-8){1'b0}}, i_shift_operand[7:0]};
  assign w_rot  = {i_shift_operand[11:8], 1'b0};
  assign w_amt  = i_shift_operand[11:7];

  // A left shift by the full width yields zero, so rotate-by-0 needs no special case.
  assign w_imm_rot = (w_imm8 >> w_rot) | (w_imm8 << (6'd32 - {1'b0, w_rot}));

  always_comb begin
    w_shifted = i_rm;
    case (shift_t'(i_shift_operand[6:5]))
      SH_LSL: w_shifted = i_rm << w_amt;
      SH_LSR: w_shifted = i_rm >> w_amt;
      SH_ASR: w_shifted = $unsigned($signed(i_rm) >>> w_amt);
      SH_ROR: w_shifted = (i_rm >> w_amt) | (i_rm << (6'd32 - {1'b0, w_amt}));
      default: w_shifted = i_rm;
    endcase
  end

  always_comb begin
    o_val2 = w_shifted;
    if (i_imm) begin
      o_val2 = w_imm_rot;
    end else if (i_mem_rw) begin
      o_val2 = {{(DATA_W-12){1'b0}}, i_shift_operand};
    end
  end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: operand forwarding, ALU, branch target adder and the
// registered status flags {N,Z,C,V}.
module exe_stage
  import arm_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic [DATA_W-1:0] pc_exe,
  input  logic [3:0]        alu_command_exe,
  input  logic              mem_read_exe,
  input  logic              mem_write_exe,
  input  logic              B_exe,
  input  logic              S_exe,
  input  logic              imm_exe,
  input  logic [23:0]       signed_immed_24_exe,
  input  logic [11:0]       shift_operand_exe,
  input  logic [DATA_W-1:0] val1_exe,
  input  logic [DATA_W-1:0] val2_exe,
  input  logic [3:0]        SR_exe,
  input  logic [1:0]        sel_src1,
  input  logic [1:0]        sel_src2,
  input  logic [DATA_W-1:0] mem_fwd,
  input  logic [DATA_W-1:0] wb_fwd,
  output logic [DATA_W-1:0] alu_res,
  output logic [DATA_W-1:0] store_val,
  output logic [DATA_W-1:0] branch_addr,
  output logic              branch_taken,
  output logic [3:0]        sr
);

  logic [DATA_W-1:0] w_op1;
  logic [DATA_W-1:0] w_rm;
  logic [DATA_W-1:0] w_val2;
  logic [DATA_W-1:0] w_b;
  logic              w_cin;
  logic              w_arith;
  logic              w_valid;
  logic [DATA_W:0]   w_sum;
  logic [DATA_W-1:0] w_res;
  logic              w_c;
  logic              w_v;
  logic [3:0]        w_flags;
  logic [3:0]        r_sr;
  logic              w_unused_nz;

  // Decode-time N and Z are never consumed; only C (carry-in) and V (passthrough) are.
  assign w_unused_nz = &{1'b0, SR_exe[3:2]};

  always_comb begin
    case (sel_src1)
      FWD_MEM: w_op1 = mem_fwd;
      FWD_WB:  w_op1 = wb_fwd;
      default: w_op1 = val1_exe;
    endcase
  end

  always_comb begin
    case (sel_src2)
      FWD_MEM: w_rm = mem_fwd;
      FWD_WB:  w_rm = wb_fwd;
      default: w_rm = val2_exe;
    endcase
  end

  val2_gen #(.DATA_W(DATA_W)) u_val2_gen (
    .i_imm           (imm_exe),
    .i_mem_rw        (mem_read_exe | mem_write_exe),
    .i_shift_operand (shift_operand_exe),
    .i_rm            (w_rm),
    .o_val2          (w_val2)
  );

  // Subtraction is op1 + ~val2 + cin so the adder carry is the ARM no-borrow flag.
  always_comb begin
    w_b     = w_val2;
    w_cin   = 1'b0;
    w_arith = 1'b0;
    w_valid = 1'b1;
    w_res   = '0;
    w_c     = SR_exe[1];
    w_v     = SR_exe[0];
    case (alu_command_exe)
      ALU_ADD: w_arith = 1'b1;
      ALU_ADC: begin w_arith = 1'b1; w_cin = SR_exe[1]; end
      ALU_SUB: begin w_arith = 1'b1; w_b = ~w_val2; w_cin = 1'b1; end
      ALU_SBC: begin w_arith = 1'b1; w_b = ~w_val2; w_cin = SR_exe[1]; end
      ALU_MOV: w_res = w_val2;
      ALU_MVN: w_res = ~w_val2;
      ALU_AND: w_res = w_op1 & w_val2;
      ALU_ORR: w_res = w_op1 | w_val2;
      ALU_EOR: w_res = w_op1 ^ w_val2;
      default: w_valid = 1'b0;
    endcase
    w_sum = {1'b0, w_op1} + {1'b0, w_b} + {{DATA_W{1'b0}}, w_cin};
    if (w_arith) begin
      w_res = w_sum[DATA_W-1:0];
      w_c   = w_sum[DATA_W];
      w_v   = (w_op1[DATA_W-1] == w_b[DATA_W-1]) && (w_res[DATA_W-1] != w_op1[DATA_W-1]);
    end
  end

  assign w_flags = w_valid ? {w_res[DATA_W-1], (w_res == '0), w_c, w_v} : r_sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sr <= 4'b0000;
    end else if (S_exe && !freeze) begin
      r_sr <= w_flags;
    end
  end

  assign alu_res      = w_res;
  assign store_val    = w_rm;
  assign branch_addr  = pc_exe + {{(DATA_W-26){signed_immed_24_exe[23]}}, signed_immed_24_exe, 2'b00};
  assign branch_taken = B_exe;
  assign sr           = r_sr;

endmodule

// File: tb/tb_exe_stage.sv
// Scoreboard bench for exe_stage: directed corner cases followed by a random
// sweep checked against a behavioural model.
module tb_exe_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic [31:0] pc_exe;
  logic [3:0]  alu_command_exe;
  logic        mem_read_exe, mem_write_exe, B_exe, S_exe, imm_exe;
  logic [23:0] signed_immed_24_exe;
  logic [11:0] shift_operand_exe;
  logic [31:0] val1_exe, val2_exe;
  logic [3:0]  SR_exe;
  logic [1:0]  sel_src1, sel_src2;
  logic [31:0] mem_fwd, wb_fwd;
  logic [31:0] alu_res, store_val, branch_addr;
  logic        branch_taken;
  logic [3:0]  sr;

  always #5 clk = ~clk;

  exe_stage #(.DATA_W(32)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .freeze              (freeze),
    .pc_exe              (pc_exe),
    .alu_command_exe     (alu_command_exe),
    .mem_read_exe        (mem_read_exe),
    .mem_write_exe       (mem_write_exe),
    .B_exe               (B_exe),
    .S_exe               (S_exe),
    .imm_exe             (imm_exe),
    .signed_immed_24_exe (signed_immed_24_exe),
    .shift_operand_exe   (shift_operand_exe),
    .val1_exe            (val1_exe),
    .val2_exe            (val2_exe),
    .SR_exe              (SR_exe),
    .sel_src1            (sel_src1),
    .sel_src2            (sel_src2),
    .mem_fwd             (mem_fwd),
    .wb_fwd              (wb_fwd),
    .alu_res             (alu_res),
    .store_val           (store_val),
    .branch_addr         (branch_addr),
    .branch_taken        (branch_taken),
    .sr                  (sr)
  );

  typedef struct {
    logic [31:0] res;
    logic [31:0] st;
    logic [31:0] br;
    logic        bt;
  } exp_t;

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  fl;
  } alu_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          errors = 0;
  logic [3:0]  m_sr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fsel(input logic [1:0] s, input logic [31:0] r,
                                       input logic [31:0] m, input logic [31:0] w);
    case (s)
      2'b01:   return m;
      2'b10:   return w;
      default: return r;
    endcase
  endfunction

  function automatic logic [31:0] m_val2(input logic imm, input logic mrw,
                                         input logic [11:0] so, input logic [31:0] rm);
    logic [31:0] v;
    int          amt;
    if (imm) begin
      v = {24'b0, so[7:0]};
      for (int i = 0; i < 2 * int'(so[11:8]); i++) v = {v[0], v[31:1]};
      return v;
    end
    if (mrw) return {20'b0, so};
    v   = rm;
    amt = int'(so[11:7]);
    for (int i = 0; i < amt; i++) begin
      case (so[6:5])
        2'b00: v = {v[30:0], 1'b0};
        2'b01: v = {1'b0, v[31:1]};
        2'b10: v = {v[31], v[31:1]};
        default: v = {v[0], v[31:1]};
      endcase
    end
    return v;
  endfunction

  function automatic alu_t m_alu(input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [3:0] srin,
                                 input logic [3:0] cur);
    longint unsigned u;
    longint          s;
    logic [31:0]     r;
    logic            c, v, ci;
    ci = srin[1];
    c  = srin[1];
    v  = srin[0];
    r  = 32'h0;
    case (op)
      4'h1: r = b;
      4'h9: r = ~b;
      4'h2, 4'h3: begin
        u = 64'(a) + 64'(b) + ((op == 4'h3) ? 64'(ci) : 64'd0);
        r = u[31:0];
        c = u[32];
        s = longint'($signed(a)) + longint'($signed(b)) + ((op == 4'h3) ? longint'(ci) : 64'sd0);
        v = (s != longint'($signed(r)));
      end
      4'h4, 4'h5: begin
        u = 64'(b) + ((op == 4'h5) ? 64'(!ci) : 64'd0);
        r = a - u[31:0];
        c = (64'(a) >= u);
        s = longint'($signed(a)) - longint'($signed(b)) - ((op == 4'h5) ? longint'(!ci) : 64'sd0);
        v = (s != longint'($signed(r)));
      end
      4'h6: r = a & b;
      4'h7: r = a | b;
      4'h8: r = a ^ b;
      default: return '{res: 32'h0, fl: cur};
    endcase
    return '{res: r, fl: {r[31], (r == 32'h0), c, v}};
  endfunction

  task automatic zero_inputs();
    freeze = 0; pc_exe = 0; alu_command_exe = 0; mem_read_exe = 0; mem_write_exe = 0;
    B_exe = 0; S_exe = 0; imm_exe = 0; signed_immed_24_exe = 0; shift_operand_exe = 0;
    val1_exe = 0; val2_exe = 0; SR_exe = 0; sel_src1 = 0; sel_src2 = 0;
    mem_fwd = 0; wb_fwd = 0;
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic step();
    exp_t        e;
    alu_t        m;
    logic [31:0] op1, rm, v2;
    op1   = fsel(sel_src1, val1_exe, mem_fwd, wb_fwd);
    rm    = fsel(sel_src2, val2_exe, mem_fwd, wb_fwd);
    v2    = m_val2(imm_exe, mem_read_exe | mem_write_exe, shift_operand_exe, rm);
    m     = m_alu(alu_command_exe, op1, v2, SR_exe, m_sr);
    e.res = m.res;
    e.st  = rm;
    e.br  = pc_exe + (32'($signed(signed_immed_24_exe)) << 2);
    e.bt  = B_exe;
    sbq.push_back(e);
    #1;
    e = sbq.pop_front();
    chk("alu_res", alu_res, e.res);
    chk("store_val", store_val, e.st);
    chk("branch_addr", branch_addr, e.br);
    chk("branch_taken", {31'b0, branch_taken}, {31'b0, e.bt});
    @(posedge clk);
    if (S_exe && !freeze) m_sr = m.fl;
    #1;
    chk("sr", {28'b0, sr}, {28'b0, m_sr});
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    zero_inputs();
    S_exe = 1'b1;
    m_sr  = 4'b0000;
    #12;
    chk("reset_sr", {28'b0, sr}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    zero_inputs();

    // ADD overflow into the sign bit
    alu_command_exe = 4'b0010; val1_exe = 32'h7FFF_FFFF; imm_exe = 1; shift_operand_exe = 12'h001; S_exe = 1;
    step();
    chk("add_ovf_res", alu_res, 32'h8000_0000);
    chk("add_ovf_sr", {28'b0, sr}, 32'h9);

    // SUB equal operands, frozen then released
    zero_inputs();
    alu_command_exe = 4'b0100; val1_exe = 32'd5; imm_exe = 1; shift_operand_exe = 12'h005; S_exe = 1; freeze = 1;
    step();
    chk("sub_frozen_sr", {28'b0, sr}, 32'h9);
    freeze = 0;
    step();
    chk("sub_released_sr", {28'b0, sr}, 32'h6);

    // Register shifts: ASR #4 and ROR #4
    zero_inputs();
    alu_command_exe = 4'b0001; val2_exe = 32'h8000_0000; shift_operand_exe = 12'h240;
    step();
    chk("mov_asr", alu_res, 32'hF800_0000);
    val2_exe = 32'h0000_000F; shift_operand_exe = 12'h260;
    step();
    chk("mov_ror", alu_res, 32'hF000_0000);

    // Rotated immediate and backward branch
    zero_inputs();
    alu_command_exe = 4'b0001; imm_exe = 1; shift_operand_exe = 12'h4FF;
    pc_exe = 32'h100; signed_immed_24_exe = 24'hFFFFFE; B_exe = 1;
    step();
    chk("imm_rot", alu_res, 32'hFF00_0000);
    chk("branch_back", branch_addr, 32'h0000_00F8);

    // Flushed bubble leaves flags alone
    zero_inputs();
    step();
    chk("bubble_sr", {28'b0, sr}, 32'h6);

    // Forwarded ADC with carry-in
    alu_command_exe = 4'b0011; sel_src1 = 2'b01; mem_fwd = 32'h10; imm_exe = 1;
    shift_operand_exe = 12'h001; SR_exe = 4'b0010; S_exe = 1;
    step();
    chk("adc_fwd", alu_res, 32'h12);

    // Asynchronous reset mid-cycle
    zero_inputs();
    alu_command_exe = 4'b0010; val1_exe = 32'h7FFF_FFFF; imm_exe = 1; shift_operand_exe = 12'h001; S_exe = 1;
    step();
    chk("pre_rst_sr", {28'b0, sr}, 32'h9);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_sr", {28'b0, sr}, 32'h0);
    chk("rst_comb_res", alu_res, 32'h8000_0000);
    @(posedge clk);
    #1;
    chk("rst_hold_sr", {28'b0, sr}, 32'h0);
    @(negedge clk);
    rst  = 1'b0;
    m_sr = 4'b0000;

    // Random sweep
    for (int n = 0; n < 200; n++) begin
      alu_command_exe     = 4'($urandom_range(0, 15));
      imm_exe             = 1'($urandom_range(0, 3) == 0);
      mem_read_exe        = 1'($urandom_range(0, 5) == 0);
      mem_write_exe       = 1'($urandom_range(0, 5) == 0);
      B_exe               = 1'($urandom);
      S_exe               = 1'($urandom);
      freeze              = 1'($urandom_range(0, 3) == 0);
      pc_exe              = $urandom;
      signed_immed_24_exe = 24'($urandom);
      shift_operand_exe   = 12'($urandom);
      val1_exe            = $urandom;
      val2_exe            = $urandom;
      SR_exe              = 4'($urandom);
      sel_src1            = 2'($urandom);
      sel_src2            = 2'($urandom);
      mem_fwd             = $urandom;
      wb_fwd              = $urandom;
      if (n % 8 == 0) begin
        val1_exe = 32'h7FFF_FFFF;
        val2_exe = 32'h8000_0000;
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exe_stage.md
EXE_STAGE -- requirements
Module: exe_stage

Interface
REQ-001 Parameter: DATA_W, 32, datapath width; only 32 is supported.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 freeze  in  1  pipeline stall; blocks the status-register update.
REQ-005 pc_exe  in  32  PC+4 of the instruction in EXE.
REQ-006 alu_command_exe  in  4  ALU opcode.
REQ-007 mem_read_exe, mem_write_exe, B_exe, S_exe, imm_exe  in  1 each  control bits.
REQ-008 signed_immed_24_exe  in  24  branch offset; shift_operand_exe  in  12  operand-2 field.
REQ-009 val1_exe, val2_exe  in  32  register operands Rn, Rm.
REQ-010 SR_exe  in  4  flags {N,Z,C,V} captured at decode; C is the carry-in.
REQ-011 sel_src1, sel_src2  in  2  forwarding select: 00 register value, 01 mem_fwd, 10 wb_fwd, 11 register value.
REQ-012 mem_fwd, wb_fwd  in  32  forwarded MEM-stage ALU result and WB value.
REQ-013 alu_res  out  32  ALU result, or memory address for LDR/STR.
REQ-014 store_val  out  32  forwarded operand 2 register value, used as STR data.
REQ-015 branch_addr  out  32  branch target; branch_taken  out  1  equals B_exe.
REQ-016 sr  out  4  registered status flags {N,Z,C,V}.

Function
REQ-017 op1 SHALL be the sel_src1-selected value of val1_exe/mem_fwd/wb_fwd; rm SHALL be the sel_src2-selected value of val2_exe/mem_fwd/wb_fwd; store_val SHALL equal rm.
REQ-018 When imm_exe=1, val2 SHALL be the zero-extended shift_operand[7:0] rotated right by 2*shift_operand[11:8].
REQ-019 When mem_read_exe or mem_write_exe is 1 (and imm_exe=0), val2 SHALL be the zero-extended shift_operand[11:0].
REQ-020 Otherwise val2 SHALL be rm shifted by shift_operand[11:7], with shift_operand[6:5] selecting LSL, LSR, ASR or ROR (00/01/10/11); a shift amount of 0 passes rm unchanged.
REQ-021 ALU opcodes: 0001 MOV=val2; 1001 MVN=~val2; 0010 ADD; 0011 ADC (op1+val2+C); 0100 SUB; 0101 SBC (op1-val2-!C); 0110 AND; 0111 ORR; 1000 EOR; any other opcode gives 0 with flags unchanged.
REQ-022 Flag rules: N=res[31]; Z=(res==0); for add/sub ops, C=carry out of bit 31 (for subtraction, C=1 means no borrow) and V=signed overflow; for logic/move ops, C and V come from SR_exe.
REQ-023 LDR/STR SHALL use ADD; CMP and TST are issued as SUB and AND with S=1, and the block does not distinguish them.
REQ-024 branch_addr SHALL equal pc_exe + (sign-extended imm24 << 2), with modulo 2^32 wrap-around.
REQ-025 All datapath outputs are combinational from the inputs, giving zero-cycle latency.
REQ-026 sr SHALL load the flags computed in REQ-022 on the rising clock edge when S_exe=1 and freeze=0; otherwise sr holds.
REQ-027 Simultaneous S_exe=1 and freeze=1: sr holds and the update is not deferred; the frozen instruction re-presents on a later cycle.
REQ-028 A flushed bubble (all inputs 0) SHALL leave sr unchanged, because S_exe=0.

Reset
REQ-029 rst=1 SHALL clear sr to 4'b0000 immediately, regardless of clk, freeze or S_exe.
REQ-030 A reset asserted mid-operation discards any pending flag update; combinational outputs continue to follow their inputs.

Structure
REQ-031 ALU opcode constants and the shift-type and forwarding-select encodings SHALL live in the shared package arm_pkg.
REQ-032 The operand-2 logic of REQ-018 to REQ-020 SHALL be a sub-module named val2_gen; the ALU and the sr register stay in exe_stage.

Verification
REQ-033 ADD with val1=0x7FFFFFFF, immediate operand 1, S=1 -> alu_res=0x80000000; next edge sr=1001 (N=1, V=1).
REQ-034 SUB with op1=5, val2=5, S=1 and freeze=1 for one cycle -> sr unchanged; after freeze drops -> sr=0110 (Z=1, C=1).
REQ-035 MOV register operand, rm=0x80000000, ASR by 4 -> alu_res=0xF8000000; ROR by 4 of 0x0000000F -> 0xF0000000.
REQ-036 Immediate rotate field 0x4FF (imm8=0xFF, rot=4) -> val2=0xFF000000; pc_exe=0x100 with imm24=0xFFFFFE -> branch_addr=0xF8.
REQ-037 sel_src1=01 with mem_fwd=0x10, ADC with val2=1 and SR_exe C=1 -> alu_res=0x12; asserting rst mid-cycle -> sr=0000 immediately.
